// File: rtl/reg_file_sb_if.sv
// Register-file bus bundle: read ports, write port, issue/scoreboard strobe, clear control, monitor tap.
// Carries no state; the master drives requests and the slave returns read data, busy flags and status.
interface reg_file_sb_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RD        = 2
);
   logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0]    rd_data;
   logic [NUM_RD-1:0]               rd_busy;
   logic                            we;
   logic [ADDRESS_WIDTH-1:0]        wa;
   logic [DATA_WIDTH-1:0]           wd;
   logic                            iss_valid;
   logic [ADDRESS_WIDTH-1:0]        iss_addr;
   logic                            clr_req;
   logic                            clr_busy;
   logic [DATA_WIDTH-1:0]           mon_data;

   modport master (
      output rd_addr, we, wa, wd, iss_valid, iss_addr, clr_req,
      input  rd_data, rd_busy, clr_busy, mon_data
   );

   modport slave (
      input  rd_addr, we, wa, wd, iss_valid, iss_addr, clr_req,
      output rd_data, rd_busy, clr_busy, mon_data
   );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, write-through read bypass and sequential clear.
// Reads are combinational, writes land on the next edge; nothing stalls, but writes/issues are dropped while clr_busy.
module reg_file_sb #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RD        = 2,
   parameter int MON_REG       = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   reg_file_sb_if.slave bus
);
   localparam int NREG = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NREG - 1);
   localparam logic [ADDRESS_WIDTH-1:0] MON_IDX  = ADDRESS_WIDTH'(MON_REG);
   localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] clr_ptr;
   logic                     clr_busy_q;
   logic [DATA_WIDTH-1:0]    regs [NREG];
   logic [NREG-1:0]          busy;
   logic [DATA_WIDTH-1:0]    mon_q;
   logic [DATA_WIDTH-1:0]    mon_next;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;
   logic                     wr_acc;
   logic                     iss_acc;

   // Register 0 is hard-wired: address 0 never writes, never issues.
   assign wr_acc  = bus.we && (bus.wa != '0) && !clr_busy_q;
   assign iss_acc = bus.iss_valid && (bus.iss_addr != '0) && !clr_busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         clr_ptr    <= FIRST_IDX;
         clr_busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.clr_req) begin
                  state      <= CLEAR;
                  clr_ptr    <= FIRST_IDX;
                  clr_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_ptr == LAST_IDX) begin
                  state      <= IDLE;
                  clr_ptr    <= FIRST_IDX;
                  clr_busy_q <= 1'b0;
               end else begin
                  clr_ptr <= clr_ptr + FIRST_IDX;
               end
            end
            default: begin
               state      <= IDLE;
               clr_ptr    <= FIRST_IDX;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (clr_busy_q && (clr_ptr == ADDRESS_WIDTH'(i)))
               regs[i] <= '0;
            else if (wr_acc && (bus.wa == ADDRESS_WIDTH'(i)))
               regs[i] <= bus.wd;
         end
      end
   end

   // Issue is applied after the write clear so a same-cycle write+issue leaves the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (clr_busy_q && (clr_ptr == ADDRESS_WIDTH'(i)))
               busy[i] <= 1'b0;
            else if (iss_acc && (bus.iss_addr == ADDRESS_WIDTH'(i)))
               busy[i] <= 1'b1;
            else if (wr_acc && (bus.wa == ADDRESS_WIDTH'(i)))
               busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      logic [ADDRESS_WIDTH-1:0] ra;
      ra        = '0;
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = bus.rd_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         if (ra == '0) begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_busy_c[k] = 1'b0;
         end else if (wr_acc && (bus.wa == ra)) begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = bus.wd;
            rd_busy_c[k] = 1'b0;
         end else begin
            rd_data_c[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
            rd_busy_c[k] = busy[ra];
         end
      end
   end

   always_comb begin
      mon_next = regs[MON_IDX];
      if (wr_acc && (bus.wa == MON_IDX)) mon_next = bus.wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mon_q <= '0;
      else        mon_q <= mon_next;
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.clr_busy = clr_busy_q;
   assign bus.mon_data = mon_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table for read/bypass/scoreboard behaviour, then fill/clear and reset-during-clear sequences.
module tb_reg_file_sb;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   logic [31:0] exp_q[$];

   reg_file_sb_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) bus();

   reg_file_sb #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .MON_REG(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iss;
      logic [4:0]  ia;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic        e_b0;
      logic        e_b1;
      logic        mon_chk;
      logic [31:0] e_mon;
   } vec_t;

   vec_t tbl[13];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.we        = 1'b0;
      bus.wa        = '0;
      bus.wd        = '0;
      bus.iss_valid = 1'b0;
      bus.iss_addr  = '0;
      bus.clr_req   = 1'b0;
   endtask

   task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
      bus.rd_addr = {a1, a0};
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act);
      logic [31:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, actual %h", nm, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, e);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      n_tests = 0;
      n_fail  = 0;

      //          we  wa     wd            iss ia    ra0    ra1    e_rd0         e_rd1         b0    b1    mchk  e_mon
      tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
      tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[6]  = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0, 5'd7,  5'd7,  32'h77,       32'h77,       1'b0, 1'b0, 1'b1, 32'h0};
      tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd0,  32'h77,       32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
      tbl[8]  = '{1'b1, 5'd7,  32'h78,       1'b1, 5'd7, 5'd7,  5'd5,  32'h78,       32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7,  5'd5,  32'h78,       32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[10] = '{1'b1, 5'd10, 32'h1234,     1'b0, 5'd0, 5'd10, 5'd9,  32'h1234,     32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
      tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd10, 5'd7,  32'h1234,     32'h78,       1'b0, 1'b1, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd3,  5'd10, 32'h0,        32'h1234,     1'b0, 1'b0, 1'b1, 32'h1234};

      rst_n = 1'b0;
      drive_idle();
      set_rd(5'd5, 5'd10);
      #2;
      push(32'h0); push(32'h0); push(32'h0); push(32'h0);
      check("reset_clr_busy", {31'b0, bus.clr_busy});
      check("reset_mon", bus.mon_data);
      check("reset_rd0", bus.rd_data[31:0]);
      check("reset_busy0", {31'b0, bus.rd_busy[0]});
      #11;
      rst_n = 1'b1;
      cyc();

      for (int i = 0; i < 13; i++) begin
         bus.we        = tbl[i].we;
         bus.wa        = tbl[i].wa;
         bus.wd        = tbl[i].wd;
         bus.iss_valid = tbl[i].iss;
         bus.iss_addr  = tbl[i].ia;
         set_rd(tbl[i].ra0, tbl[i].ra1);
         push(tbl[i].e_rd0);
         push(tbl[i].e_rd1);
         push({31'b0, tbl[i].e_b0});
         push({31'b0, tbl[i].e_b1});
         if (tbl[i].mon_chk) push(tbl[i].e_mon);
         #1;
         check($sformatf("vec%0d_rd0", i), bus.rd_data[31:0]);
         check($sformatf("vec%0d_rd1", i), bus.rd_data[63:32]);
         check($sformatf("vec%0d_busy0", i), {31'b0, bus.rd_busy[0]});
         check($sformatf("vec%0d_busy1", i), {31'b0, bus.rd_busy[1]});
         if (tbl[i].mon_chk) check($sformatf("vec%0d_mon", i), bus.mon_data);
         cyc();
      end

      // Fill 1..31 with distinct nonzero data; register 9 also gets issued so it is busy before the clear.
      for (int i = 1; i < 32; i++) begin
         drive_idle();
         bus.we        = 1'b1;
         bus.wa        = 5'(i);
         bus.wd        = 32'(i) * 32'h01010101;
         bus.iss_valid = (i == 9);
         bus.iss_addr  = 5'd9;
         set_rd(5'(i), 5'd0);
         push(32'(i) * 32'h01010101);
         #1;
         check($sformatf("fill%0d_bypass", i), bus.rd_data[31:0]);
         cyc();
      end
      drive_idle();
      set_rd(5'd9, 5'd9);
      push(32'h1);
      #1;
      check("fill_busy9", {31'b0, bus.rd_busy[0]});

      bus.clr_req = 1'b1;
      cyc();
      cnt = 0;
      while (bus.clr_busy === 1'b1 && cnt < 100) begin
         cnt++;
         drive_idle();
         if (cnt == 10) begin
            bus.we        = 1'b1;
            bus.wa        = 5'd2;
            bus.wd        = 32'hABCD;
            bus.iss_valid = 1'b1;
            bus.iss_addr  = 5'd3;
            bus.clr_req   = 1'b1;
            set_rd(5'd2, 5'd20);
            push(32'h0);
            push(32'd20 * 32'h01010101);
            push(32'h0);
            #1;
            check("mid_clear_no_bypass", bus.rd_data[31:0]);
            check("mid_clear_stored_rd", bus.rd_data[63:32]);
            check("mid_clear_busy0", {31'b0, bus.rd_busy[0]});
         end
         cyc();
      end
      drive_idle();
      push(32'd31);
      check("clear_cycles", 32'(cnt));
      push(32'h0);
      check("clear_done_mon", bus.mon_data);

      for (int r = 0; r < 32; r++) begin
         set_rd(5'(r), 5'(31 - r));
         push(32'h0); push(32'h0);
         #1;
         check($sformatf("cleared%0d_rd", r), bus.rd_data[31:0]);
         check($sformatf("cleared%0d_busy", r), {31'b0, bus.rd_busy[0]});
      end

      // Reset asserted between edges while a clear is in flight.
      cyc();
      bus.we = 1'b1; bus.wa = 5'd30; bus.wd = 32'h3030;
      cyc();
      bus.wa = 5'd10; bus.wd = 32'h1010;
      cyc();
      drive_idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd25;
      cyc();
      drive_idle();
      cyc();
      set_rd(5'd30, 5'd25);
      push(32'h3030); push(32'h1); push(32'h1010);
      #1;
      check("pre_rst_rd0", bus.rd_data[31:0]);
      check("pre_rst_busy1", {31'b0, bus.rd_busy[1]});
      check("pre_rst_mon", bus.mon_data);
      bus.clr_req = 1'b1;
      cyc();
      bus.clr_req = 1'b0;
      repeat (4) cyc();
      push(32'h1);
      check("pre_rst_clr_busy", {31'b0, bus.clr_busy});
      #2;
      rst_n = 1'b0;
      push(32'h0); push(32'h0); push(32'h0); push(32'h0);
      #1;
      check("rst_mid_rd0", bus.rd_data[31:0]);
      check("rst_mid_busy1", {31'b0, bus.rd_busy[1]});
      check("rst_mid_mon", bus.mon_data);
      check("rst_mid_clr_busy", {31'b0, bus.clr_busy});
      #1;
      rst_n = 1'b1;
      bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h33;
      set_rd(5'd3, 5'd30);
      push(32'h33);
      #1;
      check("post_rst_bypass", bus.rd_data[31:0]);
      cyc();
      drive_idle();
      push(32'h33); push(32'h0); push(32'h0);
      #1;
      check("post_rst_write3", bus.rd_data[31:0]);
      check("post_rst_reg30", bus.rd_data[63:32]);
      check("post_rst_clr_busy", {31'b0, bus.clr_busy});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
